// File: rtl/if_align_buffer.sv
// Instruction-fetch alignment buffer: turns word fetches into a stream of
// 16/32-bit RISC-V instructions, handling misaligned 32-bit encodings and redirects.
module if_align_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        fetch_req_o,
    output logic [31:0] fetch_addr_o,
    input  logic        fetch_rvalid_i,
    input  logic [31:0] fetch_rdata_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_compressed_o
);

    // Handshake: an instruction transfers on a rising edge where
    // inst_valid_o && inst_ready_i; while valid && !ready, all inst_* hold.

    logic [15:0] hb_q [3];
    logic [15:0] hb_d [3];
    logic [1:0]  count_q, count_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] faddr_q, faddr_d;
    logic        skip_q, skip_d;
    logic        outst_q, outst_d;
    logic        drop_q, drop_d;

    logic        head_32;
    logic [1:0]  head_len;
    logic        pop;
    logic        resp;
    logic        append;
    logic [1:0]  pop_len;
    logic [1:0]  app_len;
    logic [1:0]  slot0;
    logic [1:0]  slot1;
    logic [2:0]  cnt_sum;
    logic [15:0] first_hw;

    assign head_32  = (hb_q[0][1:0] == 2'b11);
    assign head_len = head_32 ? 2'd2 : 2'd1;

    assign inst_valid_o      = !redirect_i && (count_q >= head_len);
    assign inst_o            = head_32 ? {hb_q[1], hb_q[0]} : {16'h0000, hb_q[0]};
    assign inst_compressed_o = !head_32;
    assign inst_pc_o         = pc_q;

    assign fetch_req_o  = reset_n && !outst_q && !drop_q && !redirect_i &&
                          !fetch_rvalid_i && (count_q <= 2'd1);
    assign fetch_addr_o = faddr_q;

    // A response belongs to us only if we are waiting for one; stale data
    // arriving with neither flag set (e.g. after reset) is ignored.
    assign resp     = fetch_rvalid_i && (outst_q || drop_q);
    assign append   = resp && !drop_q;
    assign pop      = inst_valid_o && inst_ready_i;
    assign pop_len  = pop ? head_len : 2'd0;
    assign app_len  = append ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
    assign slot0    = count_q - pop_len;
    assign slot1    = slot0 + 2'd1;
    assign cnt_sum  = {1'b0, count_q} - {1'b0, pop_len} + {1'b0, app_len};
    assign first_hw = skip_q ? fetch_rdata_i[31:16] : fetch_rdata_i[15:0];

    always_comb begin
        hb_d    = hb_q;
        count_d = cnt_sum[1:0];
        pc_d    = pc_q;
        faddr_d = faddr_q;
        skip_d  = skip_q;
        outst_d = outst_q;
        drop_d  = drop_q && !fetch_rvalid_i;

        case (pop_len)
            2'd1: begin
                hb_d[0] = hb_q[1];
                hb_d[1] = hb_q[2];
            end
            2'd2: hb_d[0] = hb_q[2];
            default: ;
        endcase

        for (int i = 0; i < 3; i++) begin
            if ((app_len != 2'd0) && (i[1:0] == slot0)) hb_d[i] = first_hw;
            if ((app_len == 2'd2) && (i[1:0] == slot1)) hb_d[i] = fetch_rdata_i[31:16];
        end

        if (pop) pc_d = pc_q + (head_32 ? 32'd4 : 32'd2);
        if (append) skip_d = 1'b0;

        if (fetch_req_o) begin
            faddr_d = faddr_q + 32'd4;
            outst_d = 1'b1;
        end else if (resp) begin
            outst_d = 1'b0;
        end

        // Redirect flushes everything; a fetch still in flight must be dropped.
        if (redirect_i) begin
            count_d = 2'd0;
            pc_d    = redirect_pc_i & 32'hFFFF_FFFE;
            faddr_d = redirect_pc_i & 32'hFFFF_FFFC;
            skip_d  = redirect_pc_i[1];
            outst_d = 1'b0;
            drop_d  = (outst_q || drop_q) && !fetch_rvalid_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) hb_q[i] <= 16'h0000;
            count_q <= 2'd0;
            pc_q    <= RESET_PC;
            faddr_q <= {RESET_PC[31:2], 2'b00};
            skip_q  <= RESET_PC[1];
            outst_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) hb_q[i] <= hb_d[i];
            count_q <= count_d;
            pc_q    <= pc_d;
            faddr_q <= faddr_d;
            skip_q  <= skip_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!reset_n)
        (redirect_i || cnt_sum <= 3'd3));

endmodule
